// File: rtl/ee457_hdu_sb_pkg.sv
// Shared types and constants for the EE457 scoreboard hazard detection unit.
package ee457_hdu_pkg;

    // Reason the ID stage is being held; reported alongside stall.
    typedef enum logic [2:0] {
        CAUSE_NONE      = 3'd0,
        CAUSE_RAW_LD    = 3'd1,
        CAUSE_RAW_MD    = 3'd2,
        CAUSE_STRUCT_MD = 3'd3,
        CAUSE_WAW       = 3'd4
    } cause_e;

    // Which kind of producer owns a pending register result.
    typedef enum logic {
        CLS_LD = 1'b0,
        CLS_MD = 1'b1
    } lat_cls_e;

    // Width of a countdown that must hold the longer of the two latencies.
    function automatic int cnt_w(input int load_lat, input int md_lat);
        return $clog2(((load_lat > md_lat) ? load_lat : md_lat) + 1);
    endfunction

endpackage

// File: rtl/ee457_hdu_sb_if.sv
// ID-stage request and stall/flush response bundle between pipeline and HDU.
interface ee457_hdu_sb_if #(
    parameter int REG_AW = 5,
    parameter int PCW    = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_ra;
    logic              id_ra_used;
    logic [REG_AW-1:0] id_rb;
    logic              id_rb_used;
    logic [REG_AW-1:0] id_wa;
    logic              id_regwrite;
    logic              id_lw;
    logic              id_md;
    logic              ex_br_taken;
    logic              stall;
    logic              pcwrite;
    logic              irwrite;
    logic              id_ex_bubble;
    logic              if_id_flush;
    logic [2:0]        stall_cause;
    logic [PCW-1:0]    stall_cycles;

    // Pipeline side: presents the ID instruction, consumes stall/flush controls.
    modport master (
        output id_valid, id_ra, id_ra_used, id_rb, id_rb_used, id_wa,
               id_regwrite, id_lw, id_md, ex_br_taken,
        input  stall, pcwrite, irwrite, id_ex_bubble, if_id_flush,
               stall_cause, stall_cycles
    );

    // HDU side.
    modport slave (
        input  id_valid, id_ra, id_ra_used, id_rb, id_rb_used, id_wa,
               id_regwrite, id_lw, id_md, ex_br_taken,
        output stall, pcwrite, irwrite, id_ex_bubble, if_id_flush,
               stall_cause, stall_cycles
    );
endinterface

// File: rtl/ee457_hdu_sb_scoreboard.sv
// Per-register countdown of cycles until a pending result is forwardable.
module ee457_hdu_scoreboard
    import ee457_hdu_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CW     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc,
    input  logic [REG_AW-1:0] alloc_wa,
    input  logic [CW-1:0]     alloc_lat,
    input  lat_cls_e          alloc_cls,
    input  logic [REG_AW-1:0] ra,
    input  logic [REG_AW-1:0] rb,
    input  logic [REG_AW-1:0] wa,
    output logic [CW-1:0]     ra_cnt,
    output lat_cls_e          ra_cls,
    output logic [CW-1:0]     rb_cnt,
    output lat_cls_e          rb_cls,
    output logic [CW-1:0]     wa_cnt
);
    localparam int NREG = 1 << REG_AW;

    logic [CW-1:0] cnt [NREG];
    lat_cls_e      cls [NREG];

    // Allocation wins over the free-running decrement; the caller never allocates r0.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NREG; r++) begin
            if (!rst_n) begin
                cnt[r] <= '0;
                cls[r] <= CLS_LD;
            end else if (alloc && alloc_wa == REG_AW'(r)) begin
                cnt[r] <= alloc_lat;
                cls[r] <= alloc_cls;
            end else if (cnt[r] != '0) begin
                cnt[r] <= cnt[r] - CW'(1);
            end
        end
    end

    assign ra_cnt = cnt[ra];
    assign ra_cls = cls[ra];
    assign rb_cnt = cnt[rb];
    assign rb_cls = cls[rb];
    assign wa_cnt = cnt[wa];

endmodule

// File: rtl/ee457_hdu_sb.sv
// Scoreboard hazard detection unit: RAW, MUL/DIV structural and WAW stalls.
module ee457_hdu_sb
    import ee457_hdu_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int MD_LAT   = 4,
    parameter int PCW      = 16
) (
    input logic           clk,
    input logic           rst_n,
    ee457_hdu_sb_if.slave hif
);
    localparam int            CW   = cnt_w(LOAD_LAT, MD_LAT);
    localparam logic [CW-1:0] LD_L = CW'(LOAD_LAT);
    localparam logic [CW-1:0] MD_L = CW'(MD_LAT);

    logic [CW-1:0]  ra_cnt, rb_cnt, wa_cnt, lat, md_cnt;
    lat_cls_e       ra_cls, rb_cls;
    logic           raw_a, raw_b, strct, waw, stall, issue, alloc;
    cause_e         cause;
    logic [PCW-1:0] stall_cycles;

    assign lat = hif.id_lw ? LD_L : (hif.id_md ? MD_L : '0);

    // r0 never carries a pending result, so its address is masked out of every hazard.
    assign raw_a = hif.id_ra_used && hif.id_ra != '0 && ra_cnt != '0;
    assign raw_b = hif.id_rb_used && hif.id_rb != '0 && rb_cnt != '0;
    assign strct = hif.id_md && md_cnt != '0;
    // A later write may only land if it cannot complete before the older one.
    assign waw   = hif.id_regwrite && hif.id_wa != '0 && wa_cnt > lat;

    // Taken branch squashes ID, so it never stalls; reset forces a free-running pipe.
    assign stall = rst_n && hif.id_valid && !hif.ex_br_taken && (raw_a || raw_b || strct || waw);
    assign issue = rst_n && hif.id_valid && !stall && !hif.ex_br_taken;
    assign alloc = issue && hif.id_regwrite && hif.id_wa != '0 && lat != '0;

    ee457_hdu_scoreboard #(.REG_AW(REG_AW), .CW(CW)) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .alloc     (alloc),
        .alloc_wa  (hif.id_wa),
        .alloc_lat (lat),
        .alloc_cls (hif.id_md ? CLS_MD : CLS_LD),
        .ra        (hif.id_ra),
        .rb        (hif.id_rb),
        .wa        (hif.id_wa),
        .ra_cnt    (ra_cnt),
        .ra_cls    (ra_cls),
        .rb_cnt    (rb_cnt),
        .rb_cls    (rb_cls),
        .wa_cnt    (wa_cnt)
    );

    // Cause priority: RAW (rs before rt) > structural > WAW.
    always_comb begin
        cause = CAUSE_NONE;
        if (stall) begin
            if (raw_a) begin
                if (ra_cls == CLS_MD) cause = CAUSE_RAW_MD;
                else                  cause = CAUSE_RAW_LD;
            end else if (raw_b) begin
                if (rb_cls == CLS_MD) cause = CAUSE_RAW_MD;
                else                  cause = CAUSE_RAW_LD;
            end else if (strct) begin
                cause = CAUSE_STRUCT_MD;
            end else begin
                cause = CAUSE_WAW;
            end
        end
    end

    // MUL/DIV unit is not pipelined: busy for MD_LAT cycles after each issue.
    always_ff @(posedge clk) begin
        if (!rst_n)                  md_cnt <= '0;
        else if (issue && hif.id_md) md_cnt <= MD_L;
        else if (md_cnt != '0)       md_cnt <= md_cnt - CW'(1);
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (!rst_n)                         stall_cycles <= '0;
        else if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + PCW'(1);
    end

    assign hif.stall        = stall;
    assign hif.pcwrite      = !stall;
    assign hif.irwrite      = !stall;
    assign hif.id_ex_bubble = !rst_n || stall || hif.ex_br_taken || !hif.id_valid;
    assign hif.if_id_flush  = hif.ex_br_taken;
    assign hif.stall_cause  = cause;
    assign hif.stall_cycles = stall_cycles;

endmodule
